apb_spi_completer: RTL and testbench

- APB completer for the SPI peripheral window; the target of the processor-side APB bridge (3-bit PADDR, 8-bit PWDATA/PRDATA, PREADY, PSLVERR).
- Holds the SPI register file and an 8-bit SPI mode-0 master shift engine driving sclk/cs_n/mosi and sampling miso.
- Inserts APB wait states when software writes TXDATA while the shifter is busy.

---
 rtl/spi_apb_pkg.sv | 22 ++
 rtl/spi_shift_engine.sv | 80 ++++++++
 rtl/apb_spi_completer.sv | 110 +++++++++++
 tb/tb_apb_spi_completer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_apb_pkg.sv
// Shared definitions for the APB-attached SPI master:
// register indices, STATUS bit positions and engine states.
package spi_apb_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_TXDATA = 3'd2;
    localparam logic [2:0] ADDR_RXDATA = 3'd3;
    localparam logic [2:0] ADDR_CLKDIV = 3'd4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_RXV  = 1;
    localparam int STAT_OVR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL
    } eng_state_t;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 byte shifter: LEAD, 16 SHIFT half-periods, TRAIL.
// One half-period lasts div+1 clk cycles; div is re-read at each reload.
module spi_shift_engine
    import spi_apb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic [7:0] div,
    input  logic       miso,
    output logic       busy,
    output logic [7:0] rx_byte,
    output logic       rx_done,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi
);

    eng_state_t state;
    logic [7:0] cnt;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       hp_end;

    assign hp_end  = (cnt == 8'd0);
    assign busy    = (state != ST_IDLE);
    assign rx_done = (state == ST_TRAIL) && hp_end;
    assign rx_byte = shift_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            shift_reg <= 8'd0;
            bit_cnt   <= 3'd0;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
        end else begin
            if (state != ST_IDLE)
                cnt <= hp_end ? div : cnt - 8'd1;
            unique case (state)
                ST_IDLE: if (start) begin
                    state     <= ST_LEAD;
                    cnt       <= div;
                    shift_reg <= tx_byte;
                    bit_cnt   <= 3'd0;
                    cs_n      <= 1'b0;
                    mosi      <= tx_byte[7];
                end
                ST_LEAD: if (hp_end) begin
                    state     <= ST_SHIFT;
                    sclk      <= 1'b1;
                    shift_reg <= {shift_reg[6:0], miso};
                end
                ST_SHIFT: if (hp_end) begin
                    if (sclk) begin
                        sclk    <= 1'b0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt != 3'd7)
                            mosi <= shift_reg[7];
                    // bit_cnt wraps to 0 after the 8th falling edge
                    end else if (bit_cnt == 3'd0) begin
                        state <= ST_TRAIL;
                    end else begin
                        sclk      <= 1'b1;
                        shift_reg <= {shift_reg[6:0], miso};
                    end
                end
                ST_TRAIL: if (hp_end) begin
                    state <= ST_IDLE;
                    cs_n  <= 1'b1;
                    mosi  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/apb_spi_completer.sv
// APB completer for the SPI window: register file, wait-state
// insertion on TXDATA writes while busy, and the shift engine.
module apb_spi_completer
    import spi_apb_pkg::*;
#(
    parameter logic [7:0] DIV_RESET = 8'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [2:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

    logic       en;
    logic       rx_valid;
    logic       overrun;
    logic [7:0] clkdiv;
    logic [7:0] rxdata;
    logic [7:0] status;
    logic       busy;
    logic       rx_done;
    logic [7:0] rx_byte;
    logic       access;
    logic       stall;
    logic       wr;
    logic       rd;
    logic       start;

    assign access = PSEL & PENABLE;
    assign stall  = access & PWRITE & (PADDR == ADDR_TXDATA) & en & busy;
    assign PREADY = ~stall;
    assign wr     = access & ~stall & PWRITE;
    assign rd     = access & ~stall & ~PWRITE;
    assign start  = wr & (PADDR == ADDR_TXDATA) & en;

    always_comb begin
        status            = 8'd0;
        status[STAT_BUSY] = busy;
        status[STAT_RXV]  = rx_valid;
        status[STAT_OVR]  = overrun;
    end

    always_comb begin
        PRDATA  = 8'd0;
        PSLVERR = 1'b0;
        if (access) begin
            case (PADDR)
                ADDR_CTRL:   if (!PWRITE) PRDATA = {7'd0, en};
                ADDR_STATUS: if (!PWRITE) PRDATA = status;
                ADDR_TXDATA: PSLVERR = PWRITE & ~en;
                ADDR_RXDATA: if (PWRITE) PSLVERR = 1'b1;
                             else        PRDATA  = rxdata;
                ADDR_CLKDIV: if (!PWRITE) PRDATA = clkdiv;
                default:     PSLVERR = 1'b1;
            endcase
        end
    end

    // Hardware set of rx_valid/overrun beats a same-cycle software clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en       <= 1'b0;
            clkdiv   <= DIV_RESET;
            rxdata   <= 8'd0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (wr && PADDR == ADDR_CTRL)
                en <= PWDATA[0];
            if (wr && PADDR == ADDR_CLKDIV)
                clkdiv <= PWDATA;
            if (rx_done) begin
                rxdata   <= rx_byte;
                rx_valid <= 1'b1;
            end else if (rd && PADDR == ADDR_RXDATA) begin
                rx_valid <= 1'b0;
            end
            if (rx_done && rx_valid)
                overrun <= 1'b1;
            else if (wr && PADDR == ADDR_STATUS && PWDATA[STAT_OVR])
                overrun <= 1'b0;
        end
    end

    spi_shift_engine u_engine (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_byte (PWDATA),
        .div     (clkdiv),
        .miso    (miso),
        .busy    (busy),
        .rx_byte (rx_byte),
        .rx_done (rx_done),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi)
    );

endmodule

// File: tb/tb_apb_spi_completer.sv
// Bench for apb_spi_completer: cycle-level model of registers and
// SPI timing, loopback miso=mosi, directed APB sequences.
module tb_apb_spi_completer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       PSEL = 1'b0;
    logic       PENABLE = 1'b0;
    logic       PWRITE = 1'b0;
    logic [2:0] PADDR = 3'd0;
    logic [7:0] PWDATA = 8'd0;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    assign miso = mosi;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_spi_completer #(.DIV_RESET(8'd3)) dut (
        .clk     (clk),
        .rst     (rst),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso)
    );

    // Model: a transfer started at completion cycle t0 occupies cycles
    // t0+1 .. t0+18*(div+1); half-period 0 is LEAD, 1..16 SHIFT, 17 TRAIL.
    logic       m_en = 1'b0;
    logic       m_rxv = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_act = 1'b0;
    logic [7:0] m_div = 8'd3;
    logic [7:0] m_rx = 8'd0;
    logic [7:0] m_tx = 8'd0;
    int         m_t0 = 0;
    int         m_tdiv = 0;
    logic       m_busy, m_done, m_acc, m_ready, m_sclk, m_err, m_xfer;
    logic [7:0] m_prdata;
    int         hp;

    always_comb begin
        m_busy = m_act && (cyc > m_t0);
        m_done = m_act && (cyc == m_t0 + 18 * (m_tdiv + 1));
        hp = m_busy ? (cyc - m_t0 - 1) / (m_tdiv + 1) : 0;
        m_sclk = m_busy && hp >= 1 && hp <= 16 && (hp % 2 == 1);
        m_acc = PSEL && PENABLE;
        m_ready = !(m_acc && PWRITE && PADDR == 3'd2 && m_en && m_busy);
        m_xfer = m_acc && m_ready;
        m_err = 1'b0;
        m_prdata = 8'd0;
        if (m_acc) begin
            if (PADDR >= 3'd5)
                m_err = 1'b1;
            else if (PWRITE)
                m_err = (PADDR == 3'd2 && !m_en) || PADDR == 3'd3;
            else if (PADDR == 3'd0)
                m_prdata = {7'd0, m_en};
            else if (PADDR == 3'd1)
                m_prdata = {5'd0, m_ovr, m_rxv, m_busy};
            else if (PADDR == 3'd3)
                m_prdata = m_rx;
            else if (PADDR == 3'd4)
                m_prdata = m_div;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_en  <= 1'b0;
            m_div <= 8'd3;
            m_rx  <= 8'd0;
            m_rxv <= 1'b0;
            m_ovr <= 1'b0;
            m_act <= 1'b0;
        end else begin
            if (m_xfer && PWRITE) begin
                if (PADDR == 3'd0) m_en <= PWDATA[0];
                if (PADDR == 3'd4) m_div <= PWDATA;
                if (PADDR == 3'd1 && PWDATA[2]) m_ovr <= 1'b0;
                if (PADDR == 3'd2 && m_en) begin
                    m_act  <= 1'b1;
                    m_t0   <= cyc;
                    m_tdiv <= int'(m_div);
                    m_tx   <= PWDATA;
                end
            end
            if (m_xfer && !PWRITE && PADDR == 3'd3)
                m_rxv <= 1'b0;
            if (m_done) begin
                m_rx  <= m_tx;
                m_rxv <= 1'b1;
                m_act <= 1'b0;
                if (m_rxv) m_ovr <= 1'b1;
            end
        end
    end

    logic       ps = 1'b0;
    logic       bit_q[$];
    logic [7:0] rdv;
    logic       errv;
    int         tcv, tc1, tc2, wv, atv, idx;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic apb(input logic wr, input logic [2:0] a,
                       input logic [7:0] d, output logic [7:0] rd,
                       output logic err, output int tc, output int waits);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (PREADY === 1'b1) break;
            waits++;
            if (waits > 300) begin
                n_chk++; n_fail++;
                $display("FAIL apb_timeout: addr %0d still stalled", a);
                break;
            end
        end
        rd = PRDATA; err = PSLVERR; tc = cyc;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wait_idle(output int at);
        at = -1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (cs_n) begin at = cyc; break; end
        end
        if (at < 0) begin
            n_chk++; n_fail++;
            $display("FAIL idle_timeout: cs_n still low");
        end
    endtask

    task automatic check_bits(input string nm, input int from,
                              input logic [7:0] exp);
        logic [7:0] b = 8'd0;
        check({nm, "_count"}, bit_q.size() - from, 8);
        if (bit_q.size() - from == 8) begin
            for (int i = 0; i < 8; i++) b = {b[6:0], bit_q[from + i]};
            check(nm, b, exp);
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (cyc > 0) begin
                    check("cs_n", cs_n, !m_busy);
                    check("sclk", sclk, m_sclk);
                    check("pready", PREADY, m_ready);
                    if (m_acc) begin
                        check("pslverr", PSLVERR, m_err);
                        check("prdata", PRDATA, m_prdata);
                    end
                    if (!ps && sclk) bit_q.push_back(mosi);
                    ps = sclk;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_pready", PREADY, 1);
        rst = 1'b0;
        apb(0, 3'd4, 0, rdv, errv, tcv, wv); check("rst_clkdiv", rdv, 8'h03);
        apb(0, 3'd1, 0, rdv, errv, tcv, wv); check("rst_status", rdv, 8'h00);

        apb(1, 3'd0, 8'h01, rdv, errv, tcv, wv);
        apb(1, 3'd4, 8'h01, rdv, errv, tcv, wv);
        idx = bit_q.size();
        apb(1, 3'd2, 8'hA5, rdv, errv, tcv, wv);
        check("tx_a5_err", errv, 0);
        wait_idle(atv);
        check("latency_div1", atv - tcv, 37);
        check_bits("mosi_a5", idx, 8'hA5);
        apb(0, 3'd1, 0, rdv, errv, tcv, wv); check("status_rxv", rdv, 8'h02);
        apb(0, 3'd3, 0, rdv, errv, tcv, wv); check("rx_a5", rdv, 8'hA5);
        apb(0, 3'd1, 0, rdv, errv, tcv, wv); check("status_clr", rdv, 8'h00);

        apb(1, 3'd2, 8'h3C, rdv, errv, tc1, wv);
        apb(1, 3'd2, 8'hC3, rdv, errv, tc2, wv);
        check("b2b_waits", wv, 35);
        check("b2b_gap", tc2 - tc1, 37);
        wait_idle(atv);
        apb(0, 3'd1, 0, rdv, errv, tcv, wv); check("status_ovr", rdv, 8'h06);
        apb(1, 3'd1, 8'h04, rdv, errv, tcv, wv);
        apb(0, 3'd1, 0, rdv, errv, tcv, wv); check("status_w1c", rdv, 8'h02);
        apb(0, 3'd3, 0, rdv, errv, tcv, wv); check("rx_c3", rdv, 8'hC3);

        apb(1, 3'd2, 8'h96, rdv, errv, tc1, wv);
        while (cyc < tc1 + 35) begin @(posedge clk); #1; end
        apb(0, 3'd3, 0, rdv, errv, tc2, wv);
        check("simul_cycle", tc2 - tc1, 36);
        check("simul_old", rdv, 8'hC3);
        apb(0, 3'd1, 0, rdv, errv, tcv, wv); check("simul_rxv", rdv, 8'h02);
        apb(0, 3'd3, 0, rdv, errv, tcv, wv); check("simul_new", rdv, 8'h96);

        apb(1, 3'd0, 8'h00, rdv, errv, tcv, wv);
        apb(1, 3'd2, 8'h55, rdv, errv, tcv, wv);
        check("tx_dis_err", errv, 1);
        repeat (5) @(posedge clk);
        #1 check("tx_dis_cs", cs_n, 1);
        apb(1, 3'd3, 8'h11, rdv, errv, tcv, wv); check("wr_rx_err", errv, 1);
        apb(0, 3'd3, 0, rdv, errv, tcv, wv); check("rx_kept", rdv, 8'h96);
        apb(0, 3'd6, 0, rdv, errv, tcv, wv);
        check("rd6_err", errv, 1);
        check("rd6_data", rdv, 8'h00);
        check("rd6_waits", wv, 0);
        apb(1, 3'd6, 8'hFF, rdv, errv, tcv, wv); check("wr6_err", errv, 1);
        apb(0, 3'd0, 0, rdv, errv, tcv, wv); check("ctrl_ok_err", errv, 0);

        apb(1, 3'd0, 8'h01, rdv, errv, tcv, wv);
        apb(1, 3'd2, 8'hFF, rdv, errv, tc1, wv);
        while (cyc < tc1 + 20) begin @(posedge clk); #1; end
        check("mid_cs_n", cs_n, 0);
        #2 rst = 1'b1;
        #1;
        check("mrst_cs_n", cs_n, 1);
        check("mrst_sclk", sclk, 0);
        check("mrst_pready", PREADY, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        apb(0, 3'd4, 0, rdv, errv, tcv, wv); check("mrst_clkdiv", rdv, 8'h03);
        apb(0, 3'd0, 0, rdv, errv, tcv, wv); check("mrst_ctrl", rdv, 8'h00);
        apb(1, 3'd0, 8'h01, rdv, errv, tcv, wv);
        idx = bit_q.size();
        apb(1, 3'd2, 8'h5A, rdv, errv, tcv, wv);
        wait_idle(atv);
        check("latency_div3", atv - tcv, 73);
        check_bits("mosi_5a", idx, 8'h5A);
        apb(0, 3'd3, 0, rdv, errv, tcv, wv); check("rx_5a", rdv, 8'h5A);
        apb(0, 3'd1, 0, rdv, errv, tcv, wv); check("status_end", rdv, 8'h00);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
